conv_tile_scheduler: RTL and testbench
======================================

CONV_TILE_SCHEDULER -- requirements
Module: conv_tile_scheduler

Interface
REQ-001 SHALL have parameter KERNEL_HEIGHT, default 2, kernel rows.
REQ-002 SHALL have parameter KERNEL_WIDTH, default 3, kernel columns.
REQ-003 SHALL have parameter IN_CHANNELS, default 2, input channels.
REQ-004 SHALL have parameter W_SIZE, default 4, weight elements per beat per output channel.
REQ-005 SHALL have parameter OUT_CHANNELS, default 6, total output channels.
REQ-006 SHALL have parameter OUT_PARALLELISM, default 3, output channels per tile; OUT_CHANNELS divisible by it.
REQ-007 SHALL have parameter SLIDING_SIZE, default 6, output pixels per tile (out_width*out_height).
REQ-008 SHALL have one clock and a synchronous, active-low reset.
REQ-009 SHALL have port clk, input, 1, rising-edge clock.
REQ-010 SHALL have port rst, input, 1, synchronous active-low reset (0 = reset).
REQ-011 SHALL have port start, input, 1, layer start pulse.
REQ-012 SHALL have port busy, output, 1, high from accepted start until done.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at layer completion.
REQ-014 SHALL have port tile_start, output, 1, one-cycle pulse at each tile start; input streamer restarts the frame.
REQ-015 SHALL have port tile_idx, output, TILE_W=max(1,$clog2(NUM_TILES)), current tile.
REQ-016 SHALL have ports w_addr (output, W_ADDR_W=max(1,$clog2(NUM_TILES*NUM_W_BEATS))), w_req_valid (output, 1), w_req_ready (input, 1): weight-fetch request channel.
REQ-017 SHALL have ports b_addr (output, TILE_W), b_req_valid (output, 1), b_req_ready (input, 1): bias-fetch request channel.
REQ-018 SHALL have ports out_valid and out_ready, input, 1 each, monitoring the convolution output handshake.
REQ-019 SHALL have port err, output, 1, sticky protocol-error flag.

Function
REQ-020 SHALL derive NUM_W_BEATS = KERNEL_HEIGHT*KERNEL_WIDTH*IN_CHANNELS/W_SIZE and NUM_TILES = OUT_CHANNELS/OUT_PARALLELISM.
REQ-021 SHALL implement FSM states IDLE, LOAD_W, LOAD_B, DRAIN, FINISH.
REQ-022 SHALL, in IDLE on start=1, clear err, set tile 0, beat 0, pulse tile_start, and enter LOAD_W the next cycle.
REQ-023 SHALL ignore start in all states other than IDLE.
REQ-024 SHALL, in LOAD_W, hold w_req_valid=1 with w_addr=tile*NUM_W_BEATS+beat, stable until w_req_valid&w_req_ready; beat increments on each handshake.
REQ-025 SHALL enter LOAD_B after the handshake of beat NUM_W_BEATS-1, with no idle cycle between weight beats when ready stays high.
REQ-026 SHALL, in LOAD_B, hold b_req_valid=1 with b_addr=tile until handshake, then enter DRAIN.
REQ-027 SHALL, in DRAIN, count out_valid&out_ready; on count SLIDING_SIZE-1 plus handshake, either enter FINISH (last tile) or increment tile, pulse tile_start, reset beat, and enter LOAD_W.
REQ-028 SHALL count output handshakes arriving during LOAD_W/LOAD_B toward the current tile's drain count (pipeline overlap).
REQ-029 SHALL set err on an output handshake in IDLE or FINISH, or one exceeding SLIDING_SIZE within a tile; err holds until the next accepted start.
REQ-030 SHALL, in FINISH, pulse done for one cycle and return to IDLE.
REQ-031 SHALL drive busy=1 in all states except IDLE.
REQ-032 SHALL never assert w_req_valid and b_req_valid together.
REQ-033 SHALL drive all outputs from registers (zero combinational input-to-output paths).

Reset
REQ-034 SHALL, while rst=0 at a rising edge, return to IDLE mid-operation and zero busy, done, tile_start, tile_idx, w_addr, w_req_valid, b_addr, b_req_valid, err, and all counters.
REQ-035 SHALL ignore start in the cycle rst=0.

Structure
REQ-036 SHALL place the FSM state enum and the NUM_W_BEATS/NUM_TILES derivation functions in a shared package, conv_sched_pkg.
REQ-037 SHALL implement the tile/beat/pixel counters in one sub-module, sched_counter (parameterised wrap value, inc, clear, last flag).

Verification
REQ-038 SHALL verify defaults (NUM_W_BEATS=3, NUM_TILES=2), ready always 1, 6 outputs per tile -> w_addr 0,1,2 then b_addr 0; w_addr 3,4,5 then b_addr 1; done one cycle after the 12th output handshake; tile_start pulses twice.
REQ-039 SHALL verify w_req_ready toggling 1-0-1 -> w_addr held stable while ready=0, exactly 3 weight handshakes per tile.
REQ-040 SHALL verify 2 output handshakes during LOAD_W -> DRAIN ends after 4 more.
REQ-041 SHALL verify an output handshake in IDLE -> err=1; next start -> err=0.
REQ-042 SHALL verify rst=0 during DRAIN of tile 1 -> all outputs 0 the next cycle, state IDLE; a new start restarts from tile 0.
REQ-043 SHALL verify start pulsed during LOAD_B -> no effect on tile_idx or addresses.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared FSM state codes and tiling derivations for the convolution tile scheduler
package conv_sched_pkg;

    // Scheduler FSM states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_W = 3'd1;
    localparam logic [2:0] ST_LOAD_B = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    // Weight beats needed to fill one tile's kernel window
    function automatic int num_w_beats(input int kh, input int kw, input int ic, input int ws);
        return (kh * kw * ic) / ws;
    endfunction

    // Output-channel tiles per layer
    function automatic int num_tiles(input int oc, input int op);
        return oc / op;
    endfunction

    // Address/index width that never collapses to zero bits
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sched_counter.sv
// rtl/sched_counter.sv - wrapping up-counter with clear and terminal-count flag
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   clear      : return count to zero (wins over inc)
//   inc        : advance count, wrapping from WRAP-1 to zero
//   count      : current value
//   last       : count is at WRAP-1
module sched_counter #(
    parameter int WRAP  = 2,
    parameter int WIDTH = (WRAP > 1) ? $clog2(WRAP) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(WRAP - 1);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= (count == MAX) ? '0 : count + 1'b1;
        end
    end

    assign last = (count == MAX);

endmodule

// File: rtl/conv_tile_scheduler.sv
// rtl/conv_tile_scheduler.sv - per-tile weight/bias fetch sequencer that tracks convolution output drain
// Ports:
//   clk, rst                        : clock, synchronous active-low reset
//   start                           : layer start pulse (honoured only when idle)
//   busy, done                      : layer in progress / one-cycle completion pulse
//   tile_start, tile_idx            : new-tile pulse and current output-channel tile
//   w_addr, w_req_valid, w_req_ready: weight-fetch request channel
//   b_addr, b_req_valid, b_req_ready: bias-fetch request channel
//   out_valid, out_ready            : monitored convolution output handshake
//   err                             : sticky protocol error, cleared by the next accepted start
module conv_tile_scheduler
    import conv_sched_pkg::*;
#(
    parameter int KERNEL_HEIGHT   = 2,
    parameter int KERNEL_WIDTH    = 3,
    parameter int IN_CHANNELS     = 2,
    parameter int W_SIZE          = 4,
    parameter int OUT_CHANNELS    = 6,
    parameter int OUT_PARALLELISM = 3,
    parameter int SLIDING_SIZE    = 6,
    localparam int NUM_W_BEATS    = num_w_beats(KERNEL_HEIGHT, KERNEL_WIDTH, IN_CHANNELS, W_SIZE),
    localparam int NUM_TILES      = num_tiles(OUT_CHANNELS, OUT_PARALLELISM),
    localparam int TILE_W         = clog2_min1(NUM_TILES),
    localparam int W_ADDR_W       = clog2_min1(NUM_TILES * NUM_W_BEATS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                tile_start,
    output logic [TILE_W-1:0]   tile_idx,
    output logic [W_ADDR_W-1:0] w_addr,
    output logic                w_req_valid,
    input  logic                w_req_ready,
    output logic [TILE_W-1:0]   b_addr,
    output logic                b_req_valid,
    input  logic                b_req_ready,
    input  logic                out_valid,
    input  logic                out_ready,
    output logic                err
);

    localparam int BEAT_W = clog2_min1(NUM_W_BEATS);
    // Pixel counter needs one extra value so a tile that fully drained
    // during the load phases is remembered as complete.
    localparam int PIX_W  = clog2_min1(SLIDING_SIZE + 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(SLIDING_SIZE - 1);

    logic [2:0]        state;
    logic [2:0]        nxt_state;
    logic [TILE_W-1:0] tile_cnt;
    logic [TILE_W-1:0] nxt_tile;
    logic              tile_last;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] nxt_beat;
    logic              beat_last;
    logic [PIX_W-1:0]  pix_cnt;
    logic              pix_full;
    logic              out_hs;
    logic              w_hs;
    logic              b_hs;
    logic              accept;
    logic              counting;
    logic              drain_done;
    logic              tile_adv;
    logic              err_set;

    always_comb begin
        out_hs     = out_valid & out_ready;
        w_hs       = w_req_valid & w_req_ready;
        b_hs       = b_req_valid & b_req_ready;
        accept     = (state == ST_IDLE) & start;
        // Outputs overlap the next tile's loads, so they count in every busy state but FINISH.
        counting   = (state == ST_LOAD_W) | (state == ST_LOAD_B) | (state == ST_DRAIN);
        drain_done = (state == ST_DRAIN) & (pix_full | (out_hs & (pix_cnt == PIX_LAST)));
        tile_adv   = drain_done & ~tile_last;
        err_set    = out_hs & (~counting | pix_full);

        nxt_state = state;
        case (state)
            ST_IDLE:   if (accept) nxt_state = ST_LOAD_W;
            ST_LOAD_W: if (w_hs & beat_last) nxt_state = ST_LOAD_B;
            ST_LOAD_B: if (b_hs) nxt_state = ST_DRAIN;
            ST_DRAIN:  if (drain_done) nxt_state = tile_last ? ST_FINISH : ST_LOAD_W;
            default:   nxt_state = ST_IDLE;
        endcase

        nxt_tile = accept ? '0 : (tile_adv ? tile_cnt + 1'b1 : tile_cnt);
        nxt_beat = (accept | tile_adv) ? '0 : beat_cnt + 1'b1;
    end

    sched_counter #(.WRAP(NUM_TILES), .WIDTH(TILE_W)) u_tile_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .inc   (tile_adv),
        .count (tile_cnt),
        .last  (tile_last)
    );

    sched_counter #(.WRAP(NUM_W_BEATS), .WIDTH(BEAT_W)) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (accept | tile_adv),
        .inc   (w_hs),
        .count (beat_cnt),
        .last  (beat_last)
    );

    sched_counter #(.WRAP(SLIDING_SIZE + 1), .WIDTH(PIX_W)) u_pix_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (accept | drain_done),
        .inc   (out_hs & counting & ~pix_full),
        .count (pix_cnt),
        .last  (pix_full)
    );

    // The tile counter is itself a register, so it drives both index outputs directly.
    assign tile_idx = tile_cnt;
    assign b_addr   = tile_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            tile_start  <= 1'b0;
            w_addr      <= '0;
            w_req_valid <= 1'b0;
            b_req_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= nxt_state;
            busy        <= (nxt_state != ST_IDLE);
            done        <= (nxt_state == ST_FINISH);
            w_req_valid <= (nxt_state == ST_LOAD_W);
            b_req_valid <= (nxt_state == ST_LOAD_B);
            tile_start  <= accept | tile_adv;
            // After the final beat the address parks on that beat rather than following the wrapped counter.
            if (accept | tile_adv | (w_hs & ~beat_last)) begin
                w_addr <= W_ADDR_W'(nxt_tile * NUM_W_BEATS + nxt_beat);
            end
            if (accept) begin
                err <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// tb/tb_conv_tile_scheduler.sv - self-checking bench for conv_tile_scheduler with a transaction-count reference model
module tb_conv_tile_scheduler;

    localparam int NB = 3;
    localparam int NT = 2;
    localparam int SS = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       w_req_ready = 1'b0;
    logic       b_req_ready = 1'b0;
    logic       out_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;
    logic       tile_start;
    logic [0:0] tile_idx;
    logic [2:0] w_addr;
    logic       w_req_valid;
    logic [0:0] b_addr;
    logic       b_req_valid;
    logic       err;

    conv_tile_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .tile_start  (tile_start),
        .tile_idx    (tile_idx),
        .w_addr      (w_addr),
        .w_req_valid (w_req_valid),
        .w_req_ready (w_req_ready),
        .b_addr      (b_addr),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err         (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: progress of the layer as counts of completed transfers.
    bit m_active, m_fin, m_bias, m_ts, m_err;
    int m_tile, m_wb, m_pix;

    // Event log for literal checks
    int wq[$];
    int bq[$];
    int ohs_cnt, hs_edge, ts_cnt, done_edge, drain_cnt;
    int edge_n = 0;

    int  wr_mode = 0;
    int  br_mode = 0;
    int  ov_mode = 0;
    bit  tog = 1'b0;

    wire [10:0] dut_vec = {busy, done, tile_start, tile_idx, w_addr, w_req_valid, b_addr, b_req_valid, err};

    function automatic logic [10:0] exp_vec();
        int wa;
        wa = m_tile * NB + ((m_wb < NB) ? m_wb : NB - 1);
        return {m_active | m_fin, m_fin, m_ts, 1'(m_tile), 3'(wa),
                m_active && (m_wb < NB), 1'(m_tile), m_active && (m_wb == NB) && !m_bias, m_err};
    endfunction

    function automatic bit m_draining();
        return m_active && (m_wb == NB) && m_bias;
    endfunction

    always @(posedge clk) begin
        bit hs;
        bit pre_drain;
        edge_n++;
        if (w_req_valid && w_req_ready) wq.push_back(int'(w_addr));
        if (b_req_valid && b_req_ready) bq.push_back(int'(b_addr));
        hs = out_valid && out_ready;
        if (hs) begin
            ohs_cnt++;
            hs_edge = edge_n;
        end
        m_ts = 1'b0;
        if (!rst) begin
            m_active = 0; m_fin = 0; m_bias = 0; m_err = 0;
            m_tile = 0; m_wb = 0; m_pix = 0;
        end else if (m_fin) begin
            m_fin = 0;
            if (hs) m_err = 1;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_tile = 0; m_wb = 0; m_bias = 0; m_pix = 0; m_err = 0; m_ts = 1;
            end else if (hs) begin
                m_err = 1;
            end
        end else begin
            pre_drain = m_draining();
            if (m_wb < NB) begin
                if (w_req_ready) m_wb++;
            end else if (!m_bias) begin
                if (b_req_ready) m_bias = 1;
            end
            if (hs) begin
                if (m_pix == SS) m_err = 1;
                else m_pix++;
            end
            if (pre_drain && m_pix == SS) begin
                if (m_tile == NT - 1) begin
                    m_active = 0;
                    m_fin = 1;
                end else begin
                    m_tile++; m_wb = 0; m_bias = 0; m_pix = 0; m_ts = 1;
                end
            end
        end
        #1;
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL cycle%0d outputs got=%b exp=%b {busy,done,tile_start,tile_idx,w_addr,w_req_valid,b_addr,b_req_valid,err}",
                     edge_n, dut_vec, exp_vec());
        end
        if (tile_start) ts_cnt++;
        if (done) done_edge = edge_n;
        if (busy && !w_req_valid && !b_req_valid && !done) drain_cnt++;
    end

    // Input driver: ready/valid patterns chosen by the mode variables.
    initial forever begin
        @(negedge clk);
        tog = !tog;
        case (wr_mode)
            0:       w_req_ready = 1'b1;
            1:       w_req_ready = tog;
            default: w_req_ready = 1'($urandom_range(0, 1));
        endcase
        b_req_ready = (br_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        case (ov_mode)
            0: begin out_valid = 1'b0; out_ready = 1'b1; end
            1: begin out_valid = m_draining(); out_ready = 1'b1; end
            2: begin out_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1)); end
            4: begin
                out_valid = m_draining() || (m_active && m_wb < NB && m_pix < 2);
                out_ready = 1'b1;
            end
            default: out_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input longint got, input longint expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic chk_seq(input string name, input int got[$], input int expv[$]);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s: got %p expected %p", name, got, expv);
        end
    endtask

    task automatic clear_log();
        wq.delete();
        bq.delete();
        ohs_cnt = 0; hs_edge = -1; ts_cnt = 0; done_edge = -1; drain_cnt = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_edge < 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_edge >= 0, 1);
        @(negedge clk);
    endtask

    task automatic run_layer(input int budget);
        clear_log();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(budget);
    endtask

    int exp_w[$];
    int exp_b[$];

    initial begin
        exp_w = '{0, 1, 2, 3, 4, 5};
        exp_b = '{0, 1};

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", dut_vec, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Ready always high, outputs only while draining
        wr_mode = 0; br_mode = 0; ov_mode = 1;
        run_layer(200);
        chk_seq("w_addr_seq", wq, exp_w);
        chk_seq("b_addr_seq", bq, exp_b);
        chk("tile_start_pulses", ts_cnt, 2);
        chk("out_handshakes", ohs_cnt, 12);
        chk("done_after_last_hs", done_edge, hs_edge);
        chk("drain_cycles_full", drain_cnt, 12);
        chk("err_clean", err, 0);

        // Weight ready toggling
        wr_mode = 1;
        run_layer(300);
        chk_seq("w_addr_seq_toggle", wq, exp_w);
        chk_seq("b_addr_seq_toggle", bq, exp_b);

        // Two outputs overlap each tile's weight load
        wr_mode = 0; ov_mode = 4;
        run_layer(200);
        chk("drain_cycles_overlap", drain_cnt, 8);
        chk("out_handshakes_overlap", ohs_cnt, 12);
        chk("done_after_last_hs_overlap", done_edge, hs_edge);

        // Output handshake while idle
        ov_mode = 5;
        repeat (2) @(negedge clk);
        out_valid = 1'b1;
        @(negedge clk);
        out_valid = 1'b0;
        chk("err_after_idle_hs", err, 1);
        @(negedge clk);
        chk("err_held", err, 1);
        clear_log();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_cleared_by_start", err, 0);
        ov_mode = 1;
        wait_done(200);

        // Reset during tile 1 drain, then restart
        clear_log();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (!(m_tile == 1 && m_draining()) && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("reached_tile1_drain", n < 200, 1);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("outputs_after_mid_reset", dut_vec, 0);
        rst = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_from_tile0", {tile_start, tile_idx, w_addr, w_req_valid}, 6'b1_0_000_1);
        clear_log();
        wait_done(200);

        // Start pulsed during bias load is ignored
        clear_log();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (!(m_active && m_wb == NB && !m_bias) && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("reached_load_b", n < 50, 1);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignore_start_addrs", {busy, tile_idx, b_addr, w_addr}, 6'b1_0_0_010);
        chk("ignore_start_no_pulse", ts_cnt, 1);
        wait_done(200);

        // Randomized traffic on every handshake
        wr_mode = 2; br_mode = 2; ov_mode = 2;
        for (int i = 0; i < 8; i++) begin
            run_layer(3000);
            repeat (int'($urandom_range(0, 5))) @(negedge clk);
        end

        ov_mode = 0; wr_mode = 0; br_mode = 0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
